// File: rtl/fs_bus_pkg.sv
// Shared definitions for the flash/SSRAM (FS) bus write path.
// Holds the writer FSM state encoding, FS bus data/byte-enable widths,
// byte-enable patterns and the idle (inactive) levels of the SSRAM strobes.
package fs_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE,
        ST_RELEASE
    } fs_state_t;

    localparam int unsigned FS_DATA_W = 32;
    localparam int unsigned FS_BE_W   = 4;

    localparam logic [FS_BE_W-1:0] BE_ALL_N  = 4'h0;
    localparam logic [FS_BE_W-1:0] BE_NONE_N = 4'hF;

    localparam logic ADSC_IDLE_N = 1'b1;
    localparam logic WE_IDLE_N   = 1'b1;
    localparam logic OE_IDLE_N   = 1'b1;

endpackage

// File: rtl/fs_word_fifo.sv
// Synchronous first-word-fall-through FIFO of FS bus words.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush        - synchronous discard of all contents (wins over push/pop)
//   push, wdata  - write a word (ignored when full)
//   pop          - consume the head word (ignored when empty)
//   rdata        - head word, valid whenever empty is low
//   full, empty  - occupancy flags
//   count        - number of stored words
module fs_word_fifo
    import fs_bus_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic [FS_DATA_W-1:0] wdata,
    input  logic                 pop,
    output logic [FS_DATA_W-1:0] rdata,
    output logic                 full,
    output logic                 empty,
    output logic [AW:0]          count
);

    logic [FS_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cam_ssram_writer.sv
// Camera-to-SSRAM frame buffer write stage.
// Packs RGB565 pixel pairs into 32-bit words, queues them in a FIFO and
// bursts them into SSRAM as single-cycle ADSC_N-initiated writes while
// holding the shared FS bus via a req/gnt handshake.
// Ports:
//   clk, rst_n         - clock (SSRAM_CLK domain), async active-low reset
//   frame_start        - pulse: flush pending data, restart at BASE_ADDR
//   pix_valid/pix_data - pixel strobe and RGB565 value (cannot be stalled)
//   pix_ready          - room in the word FIFO
//   bus_req/bus_gnt    - shared FS bus arbitration
//   ssram_*            - SSRAM control, address, write data, DQ tri-state enable
//   frame_done         - pulse after the last word of a frame is written
//   overflow           - sticky: a pixel was dropped
module cam_ssram_writer
    import fs_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned BURST_MAX   = 8,
    parameter int unsigned FRAME_WORDS = 153600,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    input  logic [15:0]          pix_data,
    output logic                 pix_ready,
    output logic                 bus_req,
    input  logic                 bus_gnt,
    output logic                 ssram_adsc_n,
    output logic                 ssram_we_n,
    output logic                 ssram_oe_n,
    output logic [FS_BE_W-1:0]   ssram_be_n,
    output logic [ADDR_W-1:0]    ssram_addr,
    output logic [FS_DATA_W-1:0] ssram_dq_out,
    output logic                 ssram_dq_oe,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);

    fs_state_t            state;
    fs_state_t            state_nxt;
    logic                 half_valid;
    logic [15:0]          half_pix;
    logic                 accept;
    logic                 push;
    logic                 issue;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drains;
    logic                 last_in_burst;
    logic [CNT_W-1:0]     fifo_count;
    logic [FS_DATA_W-1:0] fifo_rdata;
    logic [ADDR_W-1:0]    wptr;
    logic [BURST_W-1:0]   burst_cnt;

    // A frame_start pixel is taken even when full: the flush frees the FIFO
    // in the same cycle and the pixel opens word 0 of the new frame.
    assign pix_ready = !fifo_full;
    assign accept    = pix_valid && (pix_ready || frame_start);
    assign push      = accept && half_valid && !frame_start;

    fs_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (frame_start),
        .push  (push),
        .wdata ({pix_data, half_pix}),
        .pop   (issue),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Pack register: low half of the word under construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_valid <= 1'b0;
            half_pix   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (frame_start) begin
                half_valid <= accept;
                if (accept) begin
                    half_pix <= pix_data;
                end
            end else if (accept) begin
                half_valid <= !half_valid;
                if (!half_valid) begin
                    half_pix <= pix_data;
                end
            end
            if (pix_valid && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    // Write pointer, per-grant burst count and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= FIRST_ADDR;
            burst_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start) begin
                wptr <= FIRST_ADDR;
            end else if (issue) begin
                if (wptr == LAST_ADDR) begin
                    wptr       <= FIRST_ADDR;
                    frame_done <= 1'b1;
                end else begin
                    wptr <= wptr + ADDR_W'(1);
                end
            end
            if (issue) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end else if (state != ST_WRITE) begin
                burst_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The FIFO is about to run dry when its last word leaves with no refill.
    assign fifo_drains   = (fifo_count == CNT_W'(1)) && !push;
    assign last_in_burst = (burst_cnt == BURST_W'(BURST_MAX - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!frame_start && !fifo_empty) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (frame_start) begin
                    state_nxt = ST_RELEASE;
                end else if (bus_gnt) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (frame_start) begin
                    state_nxt = ST_RELEASE;
                end else if (!bus_gnt) begin
                    state_nxt = ST_REQ;
                end else if (fifo_empty || last_in_burst || fifo_drains) begin
                    state_nxt = ST_RELEASE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state so an asynchronous reset drops the
    // strobes and the DQ drive immediately.
    always_comb begin
        bus_req = 1'b0;
        issue   = 1'b0;
        case (state)
            ST_REQ: begin
                bus_req = 1'b1;
            end
            ST_WRITE: begin
                bus_req = 1'b1;
                issue   = bus_gnt && !fifo_empty && !frame_start;
            end
            default: begin
            end
        endcase
        ssram_oe_n   = OE_IDLE_N;
        ssram_adsc_n = issue ? 1'b0 : ADSC_IDLE_N;
        ssram_we_n   = issue ? 1'b0 : WE_IDLE_N;
        ssram_be_n   = issue ? BE_ALL_N : BE_NONE_N;
        ssram_addr   = issue ? wptr : '0;
        ssram_dq_out = issue ? fifo_rdata : '0;
        ssram_dq_oe  = issue;
    end

endmodule

// File: tb/tb_cam_ssram_writer.sv
module tb_cam_ssram_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        bus_gnt;

    logic        pix_ready, bus_req, ssram_adsc_n, ssram_we_n, ssram_oe_n;
    logic [3:0]  ssram_be_n;
    logic [19:0] ssram_addr;
    logic [31:0] ssram_dq_out;
    logic        ssram_dq_oe, frame_done, overflow;

    logic        w_pix_ready, w_bus_req, w_adsc_n, w_we_n, w_oe_n;
    logic [3:0]  w_be_n;
    logic [19:0] w_addr_o;
    logic [31:0] w_dq_out;
    logic        w_dq_oe, w_frame_done, w_overflow;

    int passes = 0;
    int fails  = 0;
    int checks = 0;
    int cyc    = 0;
    int strobe_bad = 0;
    logic        rdy31, rdy32, ov32;

    logic [19:0] wr_addr[$];
    logic [31:0] wr_dq[$];
    int          wr_cyc[$];
    int          fd_cyc[$];
    logic [19:0] w_addr[$];
    logic [31:0] w_dq[$];
    int          w_cyc[$];
    int          w_fd_cyc[$];
    logic        req_log[int];

    always #5 clk = ~clk;

    cam_ssram_writer dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .ssram_adsc_n(ssram_adsc_n), .ssram_we_n(ssram_we_n), .ssram_oe_n(ssram_oe_n),
        .ssram_be_n(ssram_be_n), .ssram_addr(ssram_addr), .ssram_dq_out(ssram_dq_out),
        .ssram_dq_oe(ssram_dq_oe), .frame_done(frame_done), .overflow(overflow)
    );

    cam_ssram_writer #(.FRAME_WORDS(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(w_pix_ready),
        .bus_req(w_bus_req), .bus_gnt(bus_gnt),
        .ssram_adsc_n(w_adsc_n), .ssram_we_n(w_we_n), .ssram_oe_n(w_oe_n),
        .ssram_be_n(w_be_n), .ssram_addr(w_addr_o), .ssram_dq_out(w_dq_out),
        .ssram_dq_oe(w_dq_oe), .frame_done(w_frame_done), .overflow(w_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [15:0] base, input int i);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = base + 16'(2 * i);
        hi = base + 16'(2 * i + 1);
        return {hi, lo};
    endfunction

    task automatic clear_logs();
        wr_addr.delete(); wr_dq.delete(); wr_cyc.delete(); fd_cyc.delete();
        w_addr.delete();  w_dq.delete();  w_cyc.delete();  w_fd_cyc.delete();
        req_log.delete();
        strobe_bad = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, sample 1 ns later.
    task automatic step(input logic pv, input logic [15:0] pd, input logic fs, input logic gnt);
        @(negedge clk);
        pix_valid   = pv;
        pix_data    = pd;
        frame_start = fs;
        bus_gnt     = gnt;
        #1;
        cyc++;
        req_log[cyc] = bus_req;
        if (ssram_adsc_n === 1'b0) begin
            wr_addr.push_back(ssram_addr);
            wr_dq.push_back(ssram_dq_out);
            wr_cyc.push_back(cyc);
            if (ssram_we_n !== 1'b0 || ssram_be_n !== 4'h0 || ssram_dq_oe !== 1'b1)
                strobe_bad++;
        end else if (ssram_we_n !== 1'b1 || ssram_be_n !== 4'hF || ssram_dq_oe !== 1'b0) begin
            strobe_bad++;
        end
        if (frame_done === 1'b1) fd_cyc.push_back(cyc);
        if (w_adsc_n === 1'b0) begin
            w_addr.push_back(w_addr_o);
            w_dq.push_back(w_dq_out);
            w_cyc.push_back(cyc);
        end
        if (w_frame_done === 1'b1) w_fd_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n, input logic gnt);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, gnt);
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0; bus_gnt = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_adsc_n",     64'(ssram_adsc_n), 64'h1);
        chk("rst_we_n",       64'(ssram_we_n),   64'h1);
        chk("rst_oe_n",       64'(ssram_oe_n),   64'h1);
        chk("rst_be_n",       64'(ssram_be_n),   64'hF);
        chk("rst_addr",       64'(ssram_addr),   64'h0);
        chk("rst_dq",         64'(ssram_dq_out), 64'h0);
        chk("rst_dq_oe",      64'(ssram_dq_oe),  64'h0);
        chk("rst_bus_req",    64'(bus_req),      64'h0);
        chk("rst_frame_done", 64'(frame_done),   64'h0);
        chk("rst_overflow",   64'(overflow),     64'h0);
        chk("rst_pix_ready",  64'(pix_ready),    64'h1);
        rst_n = 1'b1;

        // Single pair: write issued 3 cycles after the second pixel
        step(1'b1, 16'h1111, 1'b0, 1'b1);
        chk("t2_a_adsc", 64'(ssram_adsc_n), 64'h1);
        step(1'b1, 16'h2222, 1'b0, 1'b1);
        chk("t2_n_req", 64'(bus_req), 64'h0);
        idle(1, 1'b1);
        chk("t2_n1_req", 64'(bus_req), 64'h0);
        idle(1, 1'b1);
        chk("t2_n2_req",  64'(bus_req),      64'h1);
        chk("t2_n2_adsc", 64'(ssram_adsc_n), 64'h1);
        idle(1, 1'b1);
        chk("t2_n3_adsc",  64'(ssram_adsc_n), 64'h0);
        chk("t2_n3_we",    64'(ssram_we_n),   64'h0);
        chk("t2_n3_be",    64'(ssram_be_n),   64'h0);
        chk("t2_n3_addr",  64'(ssram_addr),   64'h0);
        chk("t2_n3_dq",    64'(ssram_dq_out), 64'h2222_1111);
        chk("t2_n3_dq_oe", 64'(ssram_dq_oe),  64'h1);
        idle(1, 1'b1);
        chk("t2_rel_req",   64'(bus_req),     64'h0);
        chk("t2_rel_dq_oe", 64'(ssram_dq_oe), 64'h0);
        idle(3, 1'b1);

        // Burst cap: 16 words queued, 4 more arrive while writing
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) step(1'b1, 16'hA000 + 16'(k), 1'b0, 1'b0);
        clear_logs();
        idle(1, 1'b1);
        chk("t3_full_ready", 64'(pix_ready), 64'h0);
        idle(1, 1'b1);
        for (int k = 32; k < 40; k++) step(1'b1, 16'hA000 + 16'(k), 1'b0, 1'b1);
        idle(24, 1'b1);
        chk("t3_count", 64'(wr_addr.size()), 64'd20);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t3_addr%0d", i), 64'(wr_addr[i]), 64'(i));
            chk($sformatf("t3_dq%0d", i),   64'(wr_dq[i]),   64'(wd(16'hA000, i)));
        end
        for (int i = 1; i < 20; i++)
            chk($sformatf("t3_gap%0d", i), 64'(wr_cyc[i] - wr_cyc[i-1]), (i % 8 == 0) ? 64'd4 : 64'd1);
        chk("t3_rel0", 64'(req_log[wr_cyc[7] + 1]),  64'h0);
        chk("t3_rel1", 64'(req_log[wr_cyc[15] + 1]), 64'h0);
        chk("t3_rel2", 64'(req_log[wr_cyc[19] + 1]), 64'h0);
        chk("t3_strobes",  64'(strobe_bad), 64'h0);
        chk("t3_overflow", 64'(overflow),   64'h0);

        // Grant loss for 3 cycles mid-burst
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) step(1'b1, 16'hB000 + 16'(k), 1'b0, 1'b0);
        idle(1, 1'b0);
        clear_logs();
        idle(3, 1'b1);
        idle(3, 1'b0);
        idle(8, 1'b1);
        chk("t4_count", 64'(wr_addr.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t4_addr%0d", i), 64'(wr_addr[i]), 64'(i));
            chk($sformatf("t4_dq%0d", i),   64'(wr_dq[i]),   64'(wd(16'hB000, i)));
        end
        chk("t4_gap",      64'(wr_cyc[2] - wr_cyc[1]),      64'd5);
        chk("t4_gap_req",  64'(req_log[wr_cyc[1] + 2]),     64'h1);
        chk("t4_strobes",  64'(strobe_bad), 64'h0);

        // Overflow: 34 pixels with no grant
        step(1'b0, 16'h0, 1'b1, 1'b0);
        clear_logs();
        for (int k = 0; k < 34; k++) begin
            step(1'b1, 16'hC000 + 16'(k), 1'b0, 1'b0);
            if (k == 31) rdy31 = pix_ready;
            if (k == 32) begin
                rdy32 = pix_ready;
                ov32  = overflow;
            end
        end
        idle(1, 1'b0);
        chk("t5_ready31",    64'(rdy31),    64'h1);
        chk("t5_ready32",    64'(rdy32),    64'h0);
        chk("t5_ov_before",  64'(ov32),     64'h0);
        chk("t5_ov_after",   64'(overflow), 64'h1);
        idle(26, 1'b1);
        chk("t5_count",  64'(wr_addr.size()), 64'd16);
        chk("t5_dq0",    64'(wr_dq[0]),   64'(wd(16'hC000, 0)));
        chk("t5_addr15", 64'(wr_addr[15]), 64'd15);
        chk("t5_dq15",   64'(wr_dq[15]),   64'(wd(16'hC000, 15)));
        step(1'b1, 16'hD000, 1'b0, 1'b1);
        step(1'b1, 16'hD001, 1'b0, 1'b1);
        idle(6, 1'b1);
        chk("t5_next_addr", 64'(wr_addr[16]), 64'd16);
        chk("t5_next_dq",   64'(wr_dq[16]),   64'hD001_D000);

        // Wrap with a 4-word frame
        step(1'b0, 16'h0, 1'b1, 1'b1);
        clear_logs();
        for (int k = 0; k < 10; k++) step(1'b1, 16'hE000 + 16'(k), 1'b0, 1'b1);
        idle(10, 1'b1);
        chk("tw_count", 64'(w_addr.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("tw_addr%0d", i), 64'(w_addr[i]), 64'(i % 4));
        chk("tw_dq4",       64'(w_dq[4]),           64'(wd(16'hE000, 4)));
        chk("tw_fd_count",  64'(w_fd_cyc.size()),   64'd1);
        chk("tw_fd_cycle",  64'(w_fd_cyc[0] - w_cyc[3]), 64'd1);
        chk("tw_main_fd",   64'(fd_cyc.size()),     64'd0);
        chk("tw_main_addr4", 64'(wr_addr[4]),       64'd4);

        // frame_start mid-frame with words pending and a half pixel
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b1, 16'hF000 + 16'(k), 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("t6_pending_req", 64'(bus_req), 64'h1);
        clear_logs();
        step(1'b1, 16'hBEEF, 1'b1, 1'b1);
        chk("t6_fs_nowrite", 64'(ssram_adsc_n), 64'h1);
        step(1'b1, 16'hCAFE, 1'b0, 1'b1);
        chk("t6_release", 64'(bus_req), 64'h0);
        idle(6, 1'b1);
        chk("t6_count",    64'(wr_addr.size()), 64'd1);
        chk("t6_addr",     64'(wr_addr[0]),     64'h0);
        chk("t6_dq",       64'(wr_dq[0]),       64'hCAFE_BEEF);
        chk("t6_ov_stick", 64'(overflow),       64'h1);

        // Reset asserted during a write
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 16'h7000 + 16'(k), 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b1);
        chk("t1_pre_adsc", 64'(ssram_adsc_n), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("t1_adsc",     64'(ssram_adsc_n), 64'h1);
        chk("t1_we",       64'(ssram_we_n),   64'h1);
        chk("t1_be",       64'(ssram_be_n),   64'hF);
        chk("t1_dq_oe",    64'(ssram_dq_oe),  64'h0);
        chk("t1_bus_req",  64'(bus_req),      64'h0);
        chk("t1_overflow", 64'(overflow),     64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_ready", 64'(pix_ready), 64'h1);
        clear_logs();
        step(1'b1, 16'h5555, 1'b0, 1'b1);
        step(1'b1, 16'h6666, 1'b0, 1'b1);
        idle(6, 1'b1);
        chk("t1_count", 64'(wr_addr.size()), 64'd1);
        chk("t1_addr",  64'(wr_addr[0]),     64'h0);
        chk("t1_dq",    64'(wr_dq[0]),       64'h6666_5555);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
